// File: rtl/ex_mem_buffer.sv
// ex_mem_buffer: EX/MEM pipeline register with a 2-entry skid buffer.
// Captures the ALU result plus destination/control bits, derives zero and
// signed-overflow flags at capture, and hands entries to the memory stage
// over a valid/ready handshake. in_ready depends only on the state register,
// so there is no combinational path from out_ready back into execute.
// Optional feature macro: OVF_TRAP_EN (raise out_exc on overflow and suppress
// the control bits of the overflowing entry).
module ex_mem_buffer #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_co,
   input  logic              op_a_msb,
   input  logic              op_b_msb,
   input  logic              is_sub,
   input  logic              chk_ovf,
   input  logic [DATA_W-1:0] store_data,
   input  logic [REG_AW-1:0] rd_addr,
   input  logic              reg_write,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [DATA_W-1:0] out_store_data,
   output logic              out_zero,
   output logic              out_co,
   output logic              out_ovf,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_reg_write,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_exc
);

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] store_data;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              zero;
      logic              co;
      logic              ovf;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t state_reg, state_next;
   entry_t h_reg, h_next;      // head entry, drives out_*
   entry_t s_reg, s_next;      // skid entry, only valid in ST_TWO
   entry_t in_entry;
   logic   accept;
   logic   pop;
   logic   sign_match;

   assign in_ready  = (state_reg != ST_TWO);
   assign out_valid = (state_reg != ST_EMPTY);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Build the incoming entry and derive its flags from the ALU outputs
   always_comb begin
      in_entry            = '0;
      // b's sign is taken before inversion, so a subtract can only overflow
      // when the operand signs differ, an add only when they agree
      sign_match          = is_sub ? (op_a_msb != op_b_msb) : (op_a_msb == op_b_msb);
      in_entry.result     = alu_result;
      in_entry.store_data = store_data;
      in_entry.rd         = rd_addr;
      in_entry.reg_write  = reg_write;
      in_entry.mem_read   = mem_read;
      in_entry.mem_write  = mem_write;
      in_entry.zero       = (alu_result == '0);
      in_entry.co         = alu_co;
      in_entry.ovf        = chk_ovf & sign_match & (alu_result[DATA_W-1] != op_a_msb);
   end

   // Next-state and entry-load decisions; flush overrides everything
   always_comb begin
      state_next = state_reg;
      h_next     = h_reg;
      s_next     = s_reg;
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (accept) begin
                  state_next = ST_ONE;
                  h_next     = in_entry;
               end
            end
            ST_ONE: begin
               if (accept && pop) begin
                  h_next = in_entry;
               end else if (accept) begin
                  state_next = ST_TWO;
                  s_next     = in_entry;
               end else if (pop) begin
                  state_next = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  state_next = ST_ONE;
                  h_next     = s_reg;
               end
            end
            default: begin
               state_next = ST_EMPTY;
            end
         endcase
      end
   end

   // State and entry registers; reset clears everything so outputs read 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_EMPTY;
         h_reg     <= '0;
         s_reg     <= '0;
      end else begin
         state_reg <= state_next;
         h_reg     <= h_next;
         s_reg     <= s_next;
      end
   end

   assign out_result     = h_reg.result;
   assign out_store_data = h_reg.store_data;
   assign out_rd         = h_reg.rd;
   assign out_zero       = h_reg.zero;
   assign out_co         = h_reg.co;
   assign out_ovf        = h_reg.ovf;

`ifdef OVF_TRAP_EN
   // An overflowing entry traps and must not update any architectural state
   assign out_exc       = h_reg.ovf & out_valid;
   assign out_reg_write = h_reg.reg_write & ~h_reg.ovf;
   assign out_mem_read  = h_reg.mem_read  & ~h_reg.ovf;
   assign out_mem_write = h_reg.mem_write & ~h_reg.ovf;
`else
   assign out_exc       = 1'b0;
   assign out_reg_write = h_reg.reg_write;
   assign out_mem_read  = h_reg.mem_read;
   assign out_mem_write = h_reg.mem_write;
`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb_ex_mem_buffer: directed plus randomized checks of ex_mem_buffer against
// a queue-based reference model (capacity 2, FIFO order, flush empties it).
module tb_ex_mem_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] alu_result = '0;
   logic        alu_co = 1'b0;
   logic        op_a_msb = 1'b0;
   logic        op_b_msb = 1'b0;
   logic        is_sub = 1'b0;
   logic        chk_ovf = 1'b0;
   logic [31:0] store_data = '0;
   logic [4:0]  rd_addr = '0;
   logic        reg_write = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic [31:0] out_store_data;
   logic        out_zero;
   logic        out_co;
   logic        out_ovf;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        out_mem_read;
   logic        out_mem_write;
   logic        out_exc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] res;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        z;
      logic        co;
      logic        ov;
   } ent_t;

   ent_t q[$];
   ent_t pend;

   ex_mem_buffer #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .alu_co(alu_co),
      .op_a_msb(op_a_msb), .op_b_msb(op_b_msb),
      .is_sub(is_sub), .chk_ovf(chk_ovf),
      .store_data(store_data), .rd_addr(rd_addr),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_store_data(out_store_data),
      .out_zero(out_zero), .out_co(out_co), .out_ovf(out_ovf),
      .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_exc(out_exc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one execute-stage instruction: the ALU result is produced here
   // from the operands with plain arithmetic, and the model entry records
   // what the memory stage should eventually see.
   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic chk, input logic rdy, input logic fl);
      logic [32:0] wide;
      longint      sa, sb, sr;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      sr   = sub ? (sa - sb) : (sa + sb);
      wide = sub ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
      in_valid   = v;
      alu_result = wide[31:0];
      alu_co     = wide[32];
      op_a_msb   = a[31];
      op_b_msb   = b[31];
      is_sub     = sub;
      chk_ovf    = chk;
      store_data = $urandom();
      rd_addr    = 5'($urandom_range(0, 31));
      reg_write  = 1'($urandom_range(0, 1));
      mem_read   = 1'($urandom_range(0, 1));
      mem_write  = 1'($urandom_range(0, 1));
      out_ready  = rdy;
      flush      = fl;
      pend.res = wide[31:0];
      pend.sd  = store_data;
      pend.rd  = rd_addr;
      pend.rw  = reg_write;
      pend.mr  = mem_read;
      pend.mw  = mem_write;
      pend.z   = (wide[31:0] == 32'd0);
      pend.co  = wide[32];
      pend.ov  = chk && (sr > 64'sd2147483647 || sr < -64'sd2147483648);
   endtask

   task automatic check_outputs();
      ent_t e;
      logic ov_gate;
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready, q.size() < 2);
      if (q.size() != 0) begin
         e = q[0];
`ifdef OVF_TRAP_EN
         ov_gate = e.ov;
`else
         ov_gate = 1'b0;
`endif
         check("result", out_result, e.res);
         check("store_data", out_store_data, e.sd);
         check("rd", out_rd, e.rd);
         check("zero", out_zero, e.z);
         check("co", out_co, e.co);
         check("ovf", out_ovf, e.ov);
         check("reg_write", out_reg_write, e.rw & ~ov_gate);
         check("mem_read", out_mem_read, e.mr & ~ov_gate);
         check("mem_write", out_mem_write, e.mw & ~ov_gate);
         check("exc", out_exc, ov_gate);
      end else begin
         check("exc_idle", out_exc, 1'b0);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_exc", out_exc, 1'b0);
      check("rst_fields", {out_result, out_store_data},  64'd0);
      check("rst_bits", {out_zero, out_co, out_ovf, out_rd, out_reg_write,
                         out_mem_read, out_mem_write}, 64'd0);
   endtask

   // One clock: predict accept/pop from the model, advance it at the edge,
   // then compare on the falling edge.
   task automatic cycle();
      bit acc, pp;
      acc = in_valid && (q.size() < 2);
      pp  = (q.size() != 0) && out_ready;
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (pp) void'(q.pop_front());
         if (acc) q.push_back(pend);
      end
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      #2;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs();

      // Streaming 1..16 with the consumer always ready
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 32'(i), 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
         cycle();
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();

      // Backpressure: third push must wait upstream until the consumer frees space
      drive(1'b1, 32'hAAAA0000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h0000BBBB, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h12345678, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
      cycle();
      out_ready = 1'b1; cycle();
      cycle();
      in_valid = 1'b0; cycle();
      cycle();

      // Flag corner cases
      drive(1'b1, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0); cycle();
      drive(1'b1, 32'd5,        32'd5, 1'b1, 1'b1, 1'b1, 1'b0); cycle();
      drive(1'b1, 32'h80000000, 32'd1, 1'b1, 1'b1, 1'b1, 1'b0); cycle();
      drive(1'b1, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
      in_valid = 1'b0; cycle();

      // Flush in TWO together with an incoming instruction
      drive(1'b1, 32'h11, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h22, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h33, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
      drive(1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();

      // Asynchronous reset while full, in the middle of a low clock phase
      drive(1'b1, 32'h44, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h55, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      q.delete();
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 32'h66, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
      in_valid = 1'b0; out_ready = 1'b1; cycle();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a, b;
         a = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom();
         b = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom();
         if ($urandom_range(0, 7) == 0) b = a;
         drive(1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 19) == 0));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
